// File: rtl/core_crossbar_n_pkg.sv
// Shared types and default region map for core_crossbar_n.
// XBAR_TIMEOUT_EN (see core_crossbar_n) enables the BUSY timeout.
package XbarStruct;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } xbar_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } xbar_op_e;

  localparam int DEFAULT_NUM_TARGETS = 4;
  localparam int DEFAULT_ADDR_WIDTH  = 64;

  // Entry 0 = DRAM, entry 1 = MMIO, the rest unmapped (all-ones base and mask).
  localparam logic [DEFAULT_NUM_TARGETS*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_BASE = {
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'h0000_0000_0200_0000,
    64'h0000_0000_8000_0000
  };

  localparam logic [DEFAULT_NUM_TARGETS*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_MASK = {
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_0000,
    64'hFFFF_FFFF_8000_0000
  };

endpackage

// File: rtl/core_crossbar_n_decoder.sv
// Combinational address-to-target decoder; lowest matching region wins.
module addr_region_decoder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int NUM_TARGETS = 4,
  parameter int IDX_W       = $clog2(NUM_TARGETS),
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [NUM_TARGETS-1:0] match;

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_match
    assign match[g] = ((addr & REGION_MASK[g*ADDR_WIDTH +: ADDR_WIDTH])
                       == REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_crossbar_n.sv
// Single-master, N-target request crossbar with IDLE/BUSY/DONE handshake.
// Define XBAR_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES stalled cycles.
module core_crossbar_n
  import XbarStruct::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_TARGETS    = 4,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_BASE = XbarStruct::DEFAULT_BASE,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] REGION_MASK = XbarStruct::DEFAULT_MASK,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              wen_cpu,
  input  logic                              ren_cpu,
  input  logic [ADDR_WIDTH-1:0]             address_cpu,
  input  logic [DATA_WIDTH-1:0]             wdata_cpu,
  input  logic [DATA_WIDTH/8-1:0]           wmask_cpu,
  output logic [DATA_WIDTH-1:0]             rdata_cpu,
  output logic                              mem_stall,
  output logic                              access_fault,
  output logic [NUM_TARGETS-1:0]            wen_tgt,
  output logic [NUM_TARGETS-1:0]            ren_tgt,
  output logic [ADDR_WIDTH-1:0]             addr_tgt,
  output logic [DATA_WIDTH-1:0]             wdata_tgt,
  output logic [DATA_WIDTH/8-1:0]           wmask_tgt,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] rdata_tgt,
  input  logic [NUM_TARGETS-1:0]            stall_tgt
);

  localparam int IDX_W = $clog2(NUM_TARGETS);
  localparam int MW    = DATA_WIDTH / 8;

  xbar_state_e            state_q, state_d;
  xbar_op_e               op_q, op_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [MW-1:0]          wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   fault_q, fault_d;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic [DATA_WIDTH-1:0]  rdata_sel;
  logic                   stall_sel;

  addr_region_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_TARGETS (NUM_TARGETS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_dec (
    .addr (address_cpu),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the latched target's response is ever looked at.
  always_comb begin
    rdata_sel = '0;
    stall_sel = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rdata_sel = rdata_tgt[i*DATA_WIDTH +: DATA_WIDTH];
        stall_sel = stall_tgt[i];
      end
    end
  end

`ifdef XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    mem_stall = 1'b0;
    wen_tgt   = '0;
    ren_tgt   = '0;
`ifdef XBAR_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        mem_stall = wen_cpu | ren_cpu;
        if (wen_cpu || ren_cpu) begin
          if ((wen_cpu && ren_cpu) || !dec_hit) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = BUSY;
            op_d    = wen_cpu ? OP_WRITE : OP_READ;
            idx_d   = dec_idx;
            addr_d  = address_cpu;
            wdata_d = wdata_cpu;
            wmask_d = wmask_cpu;
`ifdef XBAR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            wen_tgt[i] = (op_q == OP_WRITE);
            ren_tgt[i] = (op_q == OP_READ);
          end
        end
        if (!stall_sel) begin
          state_d = DONE;
          fault_d = 1'b0;
          rdata_d = (op_q == OP_READ) ? rdata_sel : '0;
        end
`ifdef XBAR_TIMEOUT_EN
        // cnt_q counts completed BUSY cycles; this is the TIMEOUT_CYCLES-th one.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef XBAR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef XBAR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rdata_cpu    = rdata_q;
  assign access_fault = fault_q;
  assign addr_tgt     = addr_q;
  assign wdata_tgt    = wdata_q;
  assign wmask_tgt    = wmask_q;

endmodule

// File: tb/tb_core_crossbar_n.sv
// Directed bench for core_crossbar_n with three targets and TIMEOUT_CYCLES=16.
module tb_core_crossbar_n;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NT = 3;

  localparam logic [NT*AW-1:0] BASE = {
    64'h0000_0000_1000_0000, 64'h0000_0000_0200_0000, 64'h0000_0000_8000_0000};
  localparam logic [NT*AW-1:0] MASK = {
    64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_8000_0000};

  logic              clk = 1'b0;
  logic              rstn;
  logic              wen_cpu, ren_cpu;
  logic [AW-1:0]     address_cpu;
  logic [DW-1:0]     wdata_cpu;
  logic [DW/8-1:0]   wmask_cpu;
  logic [DW-1:0]     rdata_cpu;
  logic              mem_stall, access_fault;
  logic [NT-1:0]     wen_tgt, ren_tgt;
  logic [AW-1:0]     addr_tgt;
  logic [DW-1:0]     wdata_tgt;
  logic [DW/8-1:0]   wmask_tgt;
  logic [NT*DW-1:0]  rdata_tgt;
  logic [NT-1:0]     stall_tgt;

  int checks = 0;
  int errors = 0;

  core_crossbar_n #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TARGETS(NT),
    .REGION_BASE(BASE), .REGION_MASK(MASK), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn), .wen_cpu(wen_cpu), .ren_cpu(ren_cpu),
    .address_cpu(address_cpu), .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu),
    .rdata_cpu(rdata_cpu), .mem_stall(mem_stall), .access_fault(access_fault),
    .wen_tgt(wen_tgt), .ren_tgt(ren_tgt), .addr_tgt(addr_tgt),
    .wdata_tgt(wdata_tgt), .wmask_tgt(wmask_tgt),
    .rdata_tgt(rdata_tgt), .stall_tgt(stall_tgt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; checks then run 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; wen_cpu = 1'b0; ren_cpu = 1'b0; address_cpu = '0;
    wdata_cpu = '0; wmask_cpu = '0; stall_tgt = '1;
    rdata_tgt = {64'h2222_2222, 64'h1111_1111, 64'h0};
    #12;
    chk("rst_wen", 64'(wen_tgt), 64'h0);
    chk("rst_ren", 64'(ren_tgt), 64'h0);
    chk("rst_rdata", rdata_cpu, 64'h0);
    chk("rst_fault", 64'(access_fault), 64'h0);
    chk("rst_addr", addr_tgt, 64'h0);
    rstn = 1'b1;
    step();

    // T0 read, three stalled BUSY cycles
    ren_cpu = 1'b1; address_cpu = 64'h8000_1000;
    #1;
    chk("t0_c0_stall", 64'(mem_stall), 64'h1);
    chk("t0_c0_ren", 64'(ren_tgt), 64'h0);
    step(); ren_cpu = 1'b0; stall_tgt = 3'b001;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("t0_busy_ren", 64'(ren_tgt), 64'h1);
      chk("t0_busy_stall", 64'(mem_stall), 64'h1);
      step();
    end
    stall_tgt = 3'b110;
    rdata_tgt = {64'h2222_2222, 64'h1111_1111, 64'hDEAD_BEEF};
    #1;
    chk("t0_c4_ren", 64'(ren_tgt), 64'h1);
    chk("t0_c4_addr", addr_tgt, 64'h8000_1000);
    step();
    chk("t0_c5_stall", 64'(mem_stall), 64'h0);
    chk("t0_c5_ren", 64'(ren_tgt), 64'h0);
    chk("t0_c5_rdata", rdata_cpu, 64'hDEAD_BEEF);
    chk("t0_c5_fault", 64'(access_fault), 64'h0);
    step();
    chk("t0_hold", rdata_cpu, 64'hDEAD_BEEF);

    // Unmapped read
    ren_cpu = 1'b1; address_cpu = 64'h4000_0000;
    #1;
    chk("um_c0_en", 64'({wen_tgt, ren_tgt}), 64'h0);
    step(); ren_cpu = 1'b0;
    chk("um_c1_fault", 64'(access_fault), 64'h1);
    chk("um_c1_rdata", rdata_cpu, 64'h0);
    chk("um_c1_en", 64'({wen_tgt, ren_tgt}), 64'h0);
    chk("um_c1_stall", 64'(mem_stall), 64'h0);
    step();

    // T1 zero-wait write
    wen_cpu = 1'b1; address_cpu = 64'h0200_0008; wdata_cpu = 64'h1; wmask_cpu = 8'hFF;
    stall_tgt = 3'b101;
    step(); wen_cpu = 1'b0;
    chk("wr_c1_wen", 64'(wen_tgt), 64'h2);
    chk("wr_c1_ren", 64'(ren_tgt), 64'h0);
    chk("wr_c1_wmask", 64'(wmask_tgt), 64'hFF);
    chk("wr_c1_wdata", wdata_tgt, 64'h1);
    step();
    chk("wr_c2_stall", 64'(mem_stall), 64'h0);
    chk("wr_c2_wen", 64'(wen_tgt), 64'h0);
    chk("wr_c2_fault", 64'(access_fault), 64'h0);
    step();

    // Both enables together is illegal
    wen_cpu = 1'b1; ren_cpu = 1'b1; address_cpu = 64'h8000_0000;
    step(); wen_cpu = 1'b0; ren_cpu = 1'b0;
    chk("both_fault", 64'(access_fault), 64'h1);
    chk("both_rdata", rdata_cpu, 64'h0);
    chk("both_en", 64'({wen_tgt, ren_tgt}), 64'h0);
    step();

    // T2 read with a stuck target
    ren_cpu = 1'b1; address_cpu = 64'h1000_0010; stall_tgt = 3'b100;
    rdata_tgt = {64'hABCD, 64'h1111_1111, 64'h0};
    step(); ren_cpu = 1'b0;
`ifdef XBAR_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) step();
    chk("to_c16_ren", 64'(ren_tgt), 64'h4);
    step();
    chk("to_c17_stall", 64'(mem_stall), 64'h0);
    chk("to_c17_fault", 64'(access_fault), 64'h1);
    chk("to_c17_rdata", rdata_cpu, 64'h0);
    step();
`else
    for (int c = 1; c < 100; c++) step();
    chk("to_c100_stall", 64'(mem_stall), 64'h1);
    chk("to_c100_ren", 64'(ren_tgt), 64'h4);
    stall_tgt = 3'b000;
    step();
    chk("to_rel_rdata", rdata_cpu, 64'hABCD);
    chk("to_rel_fault", 64'(access_fault), 64'h0);
    step();
`endif

    // Reset pulsed during cycle 2 of a T0 read
    ren_cpu = 1'b1; address_cpu = 64'h8000_0040; stall_tgt = 3'b111;
    step(); ren_cpu = 1'b0;
    chk("rb_c1_ren", 64'(ren_tgt), 64'h1);
    step();
    rstn = 1'b0;
    #1;
    chk("rb_ren", 64'(ren_tgt), 64'h0);
    chk("rb_stall", 64'(mem_stall), 64'h0);
    chk("rb_rdata", rdata_cpu, 64'h0);
    chk("rb_fault", 64'(access_fault), 64'h0);
    chk("rb_addr", addr_tgt, 64'h0);
    #1 rstn = 1'b1;
    step();
    wen_cpu = 1'b1; address_cpu = 64'h0200_0000; wdata_cpu = 64'h5; wmask_cpu = 8'h0F;
    stall_tgt = 3'b101;
    step(); wen_cpu = 1'b0;
    chk("ra_c1_wen", 64'(wen_tgt), 64'h2);
    chk("ra_c1_addr", addr_tgt, 64'h0200_0000);
    step();
    chk("ra_c2_stall", 64'(mem_stall), 64'h0);
    chk("ra_c2_wen", 64'(wen_tgt), 64'h0);
    chk("ra_c2_fault", 64'(access_fault), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Write to T1 must never raise T0/T2 enables; tracked continuously.
  always @(negedge clk) begin
    if (rstn && address_cpu[31:24] == 8'h02 && (wen_tgt[0] || wen_tgt[2])) begin
      checks++;
      errors++;
      $error("FAIL wr_stray_wen: observed %0h expected %0h", wen_tgt, 3'b010);
    end
  end

endmodule

// File: doc/core_crossbar_n.md
CORE_CROSSBAR_N -- requirements
Module: core_crossbar_n

Interface
REQ-001 Parameters SHALL be, each as name, default, meaning:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width.
- NUM_TARGETS, 4, target port count (>=2).
- REGION_BASE, XbarStruct::DEFAULT_BASE, flattened NUM_TARGETS*ADDR_WIDTH base table.
- REGION_MASK, XbarStruct::DEFAULT_MASK, flattened compare-mask table.
- TIMEOUT_CYCLES, 1024, BUSY cycle limit.

REQ-002 Ports SHALL be, each as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- wen_cpu, in, 1, write request.
- ren_cpu, in, 1, read request.
- address_cpu, in, ADDR_WIDTH, request address.
- wdata_cpu, in, DATA_WIDTH, write data.
- wmask_cpu, in, DATA_WIDTH/8, byte mask.
- rdata_cpu, out, DATA_WIDTH, registered read data.
- mem_stall, out, 1, CPU stall.
- access_fault, out, 1, request failed (unmapped, illegal or timeout).
- wen_tgt, out, NUM_TARGETS, per-target write enable.
- ren_tgt, out, NUM_TARGETS, per-target read enable.
- addr_tgt, out, ADDR_WIDTH, latched address, broadcast to all targets.
- wdata_tgt, out, DATA_WIDTH, latched write data, broadcast.
- wmask_tgt, out, DATA_WIDTH/8, latched mask, broadcast.
- rdata_tgt, in, NUM_TARGETS*DATA_WIDTH, flattened per-target read data.
- stall_tgt, in, NUM_TARGETS, per-target busy.

Function
REQ-003 States SHALL be IDLE, BUSY and DONE.
REQ-004 IDLE: mem_stall SHALL equal (wen_cpu|ren_cpu) combinationally, and all target enables SHALL be 0.
REQ-005 Decode SHALL be, for each target i, a match when (address_cpu & MASK[i]) == BASE[i]; the lowest matching index wins.
REQ-006 On a request in IDLE with exactly one of wen_cpu/ren_cpu set and a region match:
- latch target index, op, address, wdata and wmask;
- transition to BUSY.
REQ-007 On a request in IDLE with no match, or with wen_cpu and ren_cpu both set:
- transition directly to DONE with access_fault=1 and rdata_cpu=0;
- no target enable is asserted at any point.
REQ-008 BUSY:
- drive wen_tgt[idx] or ren_tgt[idx] only; all other enables are 0;
- broadcast the latched addr/wdata/wmask;
- mem_stall=1.
REQ-009 BUSY with stall_tgt[idx]=0:
- capture rdata_tgt[idx] into rdata_cpu (writes capture 0);
- access_fault=0;
- transition to DONE.
REQ-010 DONE SHALL last exactly one cycle with mem_stall=0 and all enables 0, then transition to IDLE.
REQ-011 rdata_cpu and access_fault SHALL hold their values until the next DONE.
REQ-012 Latency SHALL be: request in cycle 0; first BUSY in cycle 1; zero-wait target gives DONE in cycle 2; each target stall cycle adds 1.
REQ-013 stall_tgt and rdata_tgt of non-selected targets SHALL be ignored.
REQ-014 wen_cpu/ren_cpu changes during BUSY SHALL be ignored (the request is already latched).

Reset
REQ-015 rstn low SHALL asynchronously force:
- state IDLE;
- wen_tgt=0 and ren_tgt=0;
- rdata_cpu=0 and access_fault=0;
- latched address/data/mask = 0;
- timeout counter = 0.
REQ-016 Reset asserted mid-BUSY SHALL abort the transaction; target enables drop in the same cycle.
REQ-017 After rstn deasserts, the first request SHALL be served per REQ-006 with no residual state.

Configuration
REQ-018 With XBAR_TIMEOUT_EN defined:
- a counter SHALL increment each BUSY cycle;
- when it reaches TIMEOUT_CYCLES with stall_tgt[idx] still 1, the block SHALL enter DONE with access_fault=1 and rdata_cpu=0;
- the counter SHALL clear on entry to BUSY.
REQ-019 Without XBAR_TIMEOUT_EN, the counter SHALL be absent and BUSY SHALL wait indefinitely.

Structure
REQ-020 Package XbarStruct SHALL hold:
- the state enum;
- DEFAULT_BASE/DEFAULT_MASK (target0 DRAM 0x8000_0000/0xFFFF_FFFF_8000_0000, target1 MMIO 0x0200_0000/0xFFFF_FFFF_FFFF_0000, remaining targets unmapped with base all-ones and mask all-ones).
REQ-021 Decode SHALL be sub-module addr_region_decoder (combinational: address -> hit, index).

Verification
Bench configuration: NUM_TARGETS=3; T0 0x8000_0000/0xFFFF_FFFF_8000_0000; T1 0x0200_0000/0xFFFF_FFFF_FFFF_0000; T2 0x1000_0000/0xFFFF_FFFF_FFFF_F000; TIMEOUT_CYCLES=16.
REQ-022 Read 0x8000_1000, T0 stall high for 3 BUSY cycles, rdata 0xDEADBEEF -> ren_tgt[0] high cycles 1-4, mem_stall high cycles 0-4 and low cycle 5, rdata_cpu=0xDEADBEEF in cycle 5.
REQ-023 Write 0x0200_0008, wmask 0xFF, wdata 0x1, T1 zero-wait -> wen_tgt[1] high cycle 1 only, wmask_tgt=0xFF, DONE in cycle 2, wen_tgt[0]/[2] never high.
REQ-024 Read 0x4000_0000 (unmapped); and separately wen_cpu=ren_cpu=1 -> in each case access_fault=1 and rdata_cpu=0 in cycle 1 with no target enable.
REQ-025 T2 read with stall_tgt[2] stuck at 1 -> with XBAR_TIMEOUT_EN: DONE in cycle 17 with access_fault=1; without it: mem_stall still 1 after 100 cycles.
REQ-026 rstn pulsed low in cycle 2 of a T0 read -> ren_tgt=0 immediately, outputs at reset values; a following write to 0x0200_0000 completes in 2 cycles.
